// File: rtl/header_word_sequencer.sv
// Marks the useful Ethernet/IP header words of each packet on the datapath with
// same-cycle strobes, and keeps packet and short-packet counts.
module header_word_sequencer #(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    CTRL_WIDTH = DATA_WIDTH / 8,
  parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL   = 8'hff
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  word_IOQ,
  output logic                  word_MAC_DST,
  output logic                  word_MAC_SRC_HI,
  output logic                  word_MAC_SRC_LO,
  output logic                  word_ETHERTYPE,
  output logic                  word_IP_TTL,
  output logic                  word_IP_CHECKSUM,
  output logic                  word_IP_SRC,
  output logic                  word_IP_DST_HI,
  output logic                  word_IP_DST_LO,
  output logic                  word_LAST_USEFUL,
  output logic                  pkt_short,
  output logic [31:0]           pkt_count,
  output logic [15:0]           short_count
);

  typedef enum logic [2:0] {
    ST_MODULE_HDRS,
    ST_WORD_1,
    ST_WORD_2,
    ST_WORD_3,
    ST_WORD_4,
    ST_WORD_5,
    ST_WAIT_EOP
  } state_t;

  state_t     state, state_next;
  logic [2:0] word_num;
  logic       eop;
  logic       short_eop;

  // Consumers tap in_data directly on the strobe cycle; the block never looks at it.
  logic unused_data;
  assign unused_data = ^in_data;

  always_comb begin
    state_next = state;
    word_num   = 3'd0;
    word_IOQ   = 1'b0;
    eop        = 1'b0;
    short_eop  = 1'b0;
    if (!reset && in_wr) begin
      case (state)
        ST_MODULE_HDRS: begin
          if (in_ctrl == IOQ_CTRL) begin
            word_IOQ = 1'b1;
          end else if (in_ctrl == '0) begin
            word_num   = 3'd1;
            state_next = ST_WORD_2;
          end
        end
        ST_WORD_1: begin
          word_num   = 3'd1;
          state_next = ST_WORD_2;
        end
        ST_WORD_2: begin
          word_num   = 3'd2;
          state_next = ST_WORD_3;
        end
        ST_WORD_3: begin
          word_num   = 3'd3;
          state_next = ST_WORD_4;
        end
        ST_WORD_4: begin
          word_num   = 3'd4;
          state_next = ST_WORD_5;
        end
        ST_WORD_5: begin
          word_num   = 3'd5;
          state_next = ST_WAIT_EOP;
        end
        ST_WAIT_EOP: state_next = ST_WAIT_EOP;
        default:     state_next = ST_MODULE_HDRS;
      endcase
      // Any nonzero control inside a packet, IOQ_CTRL included, closes it.
      if (state != ST_MODULE_HDRS && in_ctrl != '0) begin
        eop        = 1'b1;
        short_eop  = (state != ST_WORD_5) && (state != ST_WAIT_EOP);
        state_next = ST_MODULE_HDRS;
      end
    end
  end

  assign word_MAC_DST     = (word_num == 3'd1);
  assign word_MAC_SRC_HI  = (word_num == 3'd1);
  assign word_MAC_SRC_LO  = (word_num == 3'd2);
  assign word_ETHERTYPE   = (word_num == 3'd2);
  assign word_IP_TTL      = (word_num == 3'd3);
  assign word_IP_CHECKSUM = (word_num == 3'd4);
  assign word_IP_SRC      = (word_num == 3'd4);
  assign word_IP_DST_HI   = (word_num == 3'd4);
  assign word_IP_DST_LO   = (word_num == 3'd5);
  assign word_LAST_USEFUL = (word_num == 3'd5);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_MODULE_HDRS;
      pkt_short   <= 1'b0;
      pkt_count   <= 32'd0;
      short_count <= 16'd0;
    end else begin
      state     <= state_next;
      pkt_short <= short_eop;
      if (eop) pkt_count <= pkt_count + 32'd1;
      if (short_eop && short_count != 16'hffff) short_count <= short_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_header_word_sequencer.sv
// Randomized and directed checks of header_word_sequencer against a packet-level
// model that tracks the word index within the current packet.
module tb_header_word_sequencer;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam logic [CW-1:0] IOQ = 8'hff;

  localparam logic [10:0] M_IOQ = 11'b100_0000_0000;
  localparam logic [10:0] M_W1  = 11'b011_0000_0000;
  localparam logic [10:0] M_W2  = 11'b000_1100_0000;
  localparam logic [10:0] M_W3  = 11'b000_0010_0000;
  localparam logic [10:0] M_W4  = 11'b000_0001_1100;
  localparam logic [10:0] M_W5  = 11'b000_0000_0011;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          in_wr;
  logic word_IOQ, word_MAC_DST, word_MAC_SRC_HI, word_MAC_SRC_LO, word_ETHERTYPE;
  logic word_IP_TTL, word_IP_CHECKSUM, word_IP_SRC, word_IP_DST_HI, word_IP_DST_LO;
  logic word_LAST_USEFUL, pkt_short;
  logic [31:0] pkt_count;
  logic [15:0] short_count;

  int checks = 0;
  int errors = 0;

  // model state
  bit          m_in_hdr = 1'b1;
  int          m_word   = 0;
  logic [31:0] m_pkt    = '0;
  logic [15:0] m_short  = '0;
  logic        m_pulse  = 1'b0;

  // observed strobe tallies for the literal checks
  int n_ioq, n_ttl, n_chk, n_last, n_pulse;

  header_word_sequencer #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .IOQ_CTRL(IOQ)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .word_IOQ(word_IOQ), .word_MAC_DST(word_MAC_DST), .word_MAC_SRC_HI(word_MAC_SRC_HI),
    .word_MAC_SRC_LO(word_MAC_SRC_LO), .word_ETHERTYPE(word_ETHERTYPE),
    .word_IP_TTL(word_IP_TTL), .word_IP_CHECKSUM(word_IP_CHECKSUM),
    .word_IP_SRC(word_IP_SRC), .word_IP_DST_HI(word_IP_DST_HI),
    .word_IP_DST_LO(word_IP_DST_LO), .word_LAST_USEFUL(word_LAST_USEFUL),
    .pkt_short(pkt_short), .pkt_count(pkt_count), .short_count(short_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] word_mask(input int k);
    case (k)
      1: return M_W1;
      2: return M_W2;
      3: return M_W3;
      4: return M_W4;
      5: return M_W5;
      default: return 11'b0;
    endcase
  endfunction

  // Compare process: checks the current cycle, then advances the model across the edge.
  initial begin
    logic [10:0] exp_s, act_s;
    bit          nx_hdr;
    int          nx_word, k;
    logic [31:0] nx_pkt;
    logic [15:0] nx_short;
    logic        nx_pulse;
    @(posedge clk);
    forever begin
      @(negedge clk);
      act_s = {word_IOQ, word_MAC_DST, word_MAC_SRC_HI, word_MAC_SRC_LO, word_ETHERTYPE,
               word_IP_TTL, word_IP_CHECKSUM, word_IP_SRC, word_IP_DST_HI, word_IP_DST_LO,
               word_LAST_USEFUL};
      exp_s    = '0;
      nx_hdr   = m_in_hdr;
      nx_word  = m_word;
      nx_pkt   = m_pkt;
      nx_short = m_short;
      nx_pulse = 1'b0;
      if (reset) begin
        nx_hdr = 1'b1; nx_word = 0; nx_pkt = '0; nx_short = '0;
      end else if (in_wr) begin
        if (m_in_hdr) begin
          if (in_ctrl == IOQ) exp_s = M_IOQ;
          else if (in_ctrl == 0) begin
            exp_s = M_W1; nx_word = 1; nx_hdr = 1'b0;
          end
        end else begin
          k = (m_word >= 6) ? 6 : m_word + 1;
          exp_s = word_mask(k);
          nx_word = k;
          if (in_ctrl != 0) begin
            nx_pkt = m_pkt + 1;
            if (k < 5) begin
              nx_pulse = 1'b1;
              if (m_short != 16'hffff) nx_short = m_short + 1;
            end
            nx_hdr = 1'b1; nx_word = 0;
          end
        end
      end
      check("strobes", 64'(act_s), 64'(exp_s));
      check("pkt_short", 64'(pkt_short), 64'(m_pulse));
      check("pkt_count", 64'(pkt_count), 64'(m_pkt));
      check("short_count", 64'(short_count), 64'(m_short));
      if (word_IOQ) n_ioq++;
      if (word_IP_TTL) n_ttl++;
      if (word_IP_CHECKSUM) n_chk++;
      if (word_LAST_USEFUL) n_last++;
      if (pkt_short) n_pulse++;
      m_in_hdr = nx_hdr; m_word = nx_word; m_pkt = nx_pkt;
      m_short = nx_short; m_pulse = nx_pulse;
    end
  end

  task automatic send_word(input logic [CW-1:0] ctrl);
    in_wr   = 1'b1;
    in_ctrl = ctrl;
    in_data = {$urandom, $urandom};
    @(posedge clk); #1;
    in_wr   = 1'b0;
    in_ctrl = CW'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_reset();
    reset   = 1'b1;
    in_wr   = 1'($urandom);
    in_ctrl = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    in_wr = 1'b0;
  endtask

  task automatic clear_tallies();
    n_ioq = 0; n_ttl = 0; n_chk = 0; n_last = 0; n_pulse = 0;
  endtask

  task automatic nominal_pkt(input int gap_after_w2);
    send_word(8'hff);
    send_word(8'h01);
    for (int i = 1; i <= 6; i++) begin
      send_word(8'h00);
      if (i == 2) idle(gap_after_w2);
    end
    send_word(8'h01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nh, len;
    logic [CW-1:0] c;
    reset = 1'b1; in_wr = 1'b1; in_ctrl = '0; in_data = '0;
    clear_tallies();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0; in_wr = 1'b0;
    check("reset pkt_count", 64'(pkt_count), 64'h0);
    check("reset short_count", 64'(short_count), 64'h0);
    check("reset pkt_short", 64'(pkt_short), 64'h0);

    // nominal packet
    clear_tallies();
    nominal_pkt(0);
    idle(2);
    check("nominal pkt_count", 64'(pkt_count), 64'd1);
    check("nominal short_count", 64'(short_count), 64'd0);
    check("nominal ioq strobes", 64'(n_ioq), 64'd1);
    check("nominal last_useful", 64'(n_last), 64'd1);
    check("nominal short pulses", 64'(n_pulse), 64'd0);

    // short packet, EOP on word 3
    pulse_reset();
    clear_tallies();
    send_word(8'hff);
    send_word(8'h00);
    send_word(8'h00);
    send_word(8'h01);
    idle(2);
    check("short ttl", 64'(n_ttl), 64'd1);
    check("short checksum", 64'(n_chk), 64'd0);
    check("short last_useful", 64'(n_last), 64'd0);
    check("short pulses", 64'(n_pulse), 64'd1);
    check("short pkt_count", 64'(pkt_count), 64'd1);
    check("short short_count", 64'(short_count), 64'd1);

    // gaps inside a packet, then a back-to-back packet
    pulse_reset();
    clear_tallies();
    nominal_pkt(3);
    nominal_pkt(0);
    idle(1);
    check("b2b pkt_count", 64'(pkt_count), 64'd2);
    check("b2b last_useful", 64'(n_last), 64'd2);
    check("b2b ioq", 64'(n_ioq), 64'd2);

    // reset mid-packet
    send_word(8'hff);
    send_word(8'h00);
    send_word(8'h00);
    pulse_reset();
    check("midreset pkt_count", 64'(pkt_count), 64'd0);
    clear_tallies();
    nominal_pkt(0);
    idle(1);
    check("midreset then pkt_count", 64'(pkt_count), 64'd1);
    check("midreset last_useful", 64'(n_last), 64'd1);

    // saturation and wrap
    #1;
    force dut.pkt_count = 32'hffffffff;
    force dut.short_count = 16'hffff;
    m_pkt = 32'hffffffff;
    m_short = 16'hffff;
    #1;
    release dut.pkt_count;
    release dut.short_count;
    @(posedge clk); #1;
    send_word(8'hff);
    send_word(8'h00);
    send_word(8'h00);
    send_word(8'hff);
    idle(1);
    check("wrap pkt_count", 64'(pkt_count), 64'd0);
    check("sat short_count", 64'(short_count), 64'hffff);

    // randomized packets
    pulse_reset();
    for (int p = 0; p < 300; p++) begin
      nh = $urandom_range(0, 3);
      for (int h = 0; h < nh; h++) begin
        c = ($urandom_range(0, 1) == 1) ? IOQ : CW'($urandom_range(1, 254));
        send_word(c);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      send_word(8'h00);
      if ($urandom_range(0, 24) == 0) begin
        pulse_reset();
        continue;
      end
      len = $urandom_range(2, 8);
      for (int w = 2; w <= len; w++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        if (w == len) begin
          c = ($urandom_range(0, 3) == 0) ? IOQ : CW'($urandom_range(1, 255));
          send_word(c);
        end else begin
          send_word(8'h00);
        end
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
